disp_timing_gen: RTL and testbench

Video timing generator that consumes the display pixel clock and reset from the display clock/reset distribution stage. It produces hsync, vsync, data-enable, pixel coordinates and a look-ahead pixel request for the framebuffer reader. It is one instance per display port: VGA, LCD or HDMI encoder input. Porch, sync and polarity values are set by parameters, and the prefetch distance is configurable.

---
 rtl/disp_pkg.sv | 61 ++++++
 rtl/disp_delay_line.sv | 43 ++++
 rtl/disp_timing_gen.sv | 153 +++++++++++++++
 tb/tb_disp_timing_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared constants, timing presets and total-size helpers for
//                the display timing generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // Width of every pixel coordinate and of the raster counters
    localparam int c_COORD_W   = 12;
    // Largest H/V total the coordinate width can address
    localparam int c_MAX_TOTAL = 4096;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit hs_pol;
        bit vs_pol;
    } disp_timing_t;

    localparam disp_timing_t c_T_640X480_60 = '{
        h_active: 640,  h_fp: 16,  h_sync: 96,  h_bp: 48,
        v_active: 480,  v_fp: 10,  v_sync: 2,   v_bp: 33,
        hs_pol: 1'b0,   vs_pol: 1'b0};

    localparam disp_timing_t c_T_800X600_60 = '{
        h_active: 800,  h_fp: 40,  h_sync: 128, h_bp: 88,
        v_active: 600,  v_fp: 1,   v_sync: 4,   v_bp: 23,
        hs_pol: 1'b1,   vs_pol: 1'b1};

    localparam disp_timing_t c_T_1280X720_60 = '{
        h_active: 1280, h_fp: 110, h_sync: 40,  h_bp: 220,
        v_active: 720,  v_fp: 5,   v_sync: 5,   v_bp: 20,
        hs_pol: 1'b1,   vs_pol: 1'b1};

    localparam disp_timing_t c_T_480X272_LCD = '{
        h_active: 480,  h_fp: 2,   h_sync: 41,  h_bp: 2,
        v_active: 272,  v_fp: 2,   v_sync: 10,  v_bp: 2,
        hs_pol: 1'b0,   vs_pol: 1'b0};

    // Clocks per line
    function automatic int h_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Lines per frame
    function automatic int v_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : disp_delay_line
//  Description : Fixed-depth shift register with synchronous active-low
//                clear. Depth 0 degenerates to a wire.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_sr [DEPTH];

            // Shift one stage per clock; clear drops every stage to zero at once
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_sr[i] <= '0;
                    end
                end else begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/disp_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : disp_timing_gen
//  Description : Raster timing generator. Raster counters feed a registered
//                decode stage; pix_req/req_x/req_y come straight from it and
//                the display-side signals follow through a PREFETCH-deep
//                delay line. Sync polarity is applied only at the outputs so
//                that cleared pipeline state always reads as "inactive".
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_timing_gen
    import disp_pkg::*;
#(
    parameter int H_ACTIVE = c_T_800X600_60.h_active,
    parameter int H_FP     = c_T_800X600_60.h_fp,
    parameter int H_SYNC   = c_T_800X600_60.h_sync,
    parameter int H_BP     = c_T_800X600_60.h_bp,
    parameter int V_ACTIVE = c_T_800X600_60.v_active,
    parameter int V_FP     = c_T_800X600_60.v_fp,
    parameter int V_SYNC   = c_T_800X600_60.v_sync,
    parameter int V_BP     = c_T_800X600_60.v_bp,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int PREFETCH = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    output logic                 pix_req,
    output logic [c_COORD_W-1:0] req_x,
    output logic [c_COORD_W-1:0] req_y,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [c_COORD_W-1:0] pix_x,
    output logic [c_COORD_W-1:0] pix_y,
    output logic                 sof
);

    localparam int c_H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // One extra bit so region boundaries equal to 4096 compare correctly
    localparam int c_CMP_W = c_COORD_W + 1;
    localparam logic [c_CMP_W-1:0] c_H_ACT    = c_CMP_W'(H_ACTIVE);
    localparam logic [c_CMP_W-1:0] c_H_HS_ON  = c_CMP_W'(H_ACTIVE + H_FP);
    localparam logic [c_CMP_W-1:0] c_H_HS_OFF = c_CMP_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_CMP_W-1:0] c_V_ACT    = c_CMP_W'(V_ACTIVE);
    localparam logic [c_CMP_W-1:0] c_V_VS_ON  = c_CMP_W'(V_ACTIVE + V_FP);
    localparam logic [c_CMP_W-1:0] c_V_VS_OFF = c_CMP_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [c_COORD_W-1:0] c_H_LAST = c_COORD_W'(c_H_TOTAL - 1);
    localparam logic [c_COORD_W-1:0] c_V_LAST = c_COORD_W'(c_V_TOTAL - 1);

    // {req, x, y, hs, vs, sof}
    localparam int c_DL_W = 4 + 2 * c_COORD_W;

    logic [c_COORD_W-1:0] r_h_cnt;
    logic [c_COORD_W-1:0] r_v_cnt;

    logic                 r_req;
    logic [c_COORD_W-1:0] r_req_x;
    logic [c_COORD_W-1:0] r_req_y;
    logic                 r_hs;
    logic                 r_vs;
    logic                 r_sof;

    logic [c_CMP_W-1:0]   w_h;
    logic [c_CMP_W-1:0]   w_v;
    logic                 w_req;
    logic                 w_hs;
    logic                 w_vs;
    logic                 w_run;

    logic [c_DL_W-1:0]    w_dl_in;
    logic [c_DL_W-1:0]    w_dl_out;
    logic                 w_de;
    logic [c_COORD_W-1:0] w_pix_x;
    logic [c_COORD_W-1:0] w_pix_y;
    logic                 w_hs_d;
    logic                 w_vs_d;
    logic                 w_sof_d;

    assign w_run = rstn && en;

    // Raster counters: held at the frame origin while stopped, so an en rise restarts at (0,0)
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // Region decode of the current counter position
    always_comb begin
        w_h   = {1'b0, r_h_cnt};
        w_v   = {1'b0, r_v_cnt};
        w_req = (w_h < c_H_ACT) && (w_v < c_V_ACT);
        w_hs  = (w_h >= c_H_HS_ON) && (w_h < c_H_HS_OFF);
        w_vs  = (w_v >= c_V_VS_ON) && (w_v < c_V_VS_OFF);
    end

    // Decode register: drives the request side directly and feeds the delay line
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_req   <= 1'b0;
            r_req_x <= '0;
            r_req_y <= '0;
            r_hs    <= 1'b0;
            r_vs    <= 1'b0;
            r_sof   <= 1'b0;
        end else begin
            r_req   <= w_req;
            r_req_x <= w_req ? r_h_cnt : '0;
            r_req_y <= w_req ? r_v_cnt : '0;
            r_hs    <= w_hs;
            r_vs    <= w_vs;
            r_sof   <= w_req && (r_h_cnt == '0) && (r_v_cnt == '0);
        end
    end

    assign w_dl_in = {r_req, r_req_x, r_req_y, r_hs, r_vs, r_sof};

    // Only reset clears the delay line; en low lets it drain the cleared decode values
    disp_delay_line #(
        .WIDTH (c_DL_W),
        .DEPTH (PREFETCH)
    ) u_delay (
        .clk  (clk),
        .rstn (rstn),
        .i_d  (w_dl_in),
        .o_q  (w_dl_out)
    );

    assign {w_de, w_pix_x, w_pix_y, w_hs_d, w_vs_d, w_sof_d} = w_dl_out;

    assign pix_req = r_req;
    assign req_x   = r_req_x;
    assign req_y   = r_req_y;
    assign de      = w_de;
    assign pix_x   = w_pix_x;
    assign pix_y   = w_pix_y;
    assign sof     = w_sof_d;
    assign hsync   = HS_POL ? w_hs_d : ~w_hs_d;
    assign vsync   = VS_POL ? w_vs_d : ~w_vs_d;

endmodule
`default_nettype wire

// File: tb/tb_disp_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_timing_gen
//  Description : Self-checking bench for disp_timing_gen on a small raster
//                (14 x 7), three instances differing in polarity and
//                prefetch depth, compared each clock against a raster model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_timing_gen;

    localparam int c_HA = 8, c_HF = 2, c_HS = 2, c_HB = 2;
    localparam int c_VA = 4, c_VF = 1, c_VS = 1, c_VB = 1;
    localparam int c_HT = c_HA + c_HF + c_HS + c_HB;
    localparam int c_VT = c_VA + c_VF + c_VS + c_VB;
    localparam int c_FRAME = c_HT * c_VT;
    localparam int c_N = 3;

    // Per-instance configuration
    localparam int c_PF   [c_N] = '{2, 0, 4};
    localparam bit c_HPOL [c_N] = '{1'b1, 1'b0, 1'b0};
    localparam bit c_VPOL [c_N] = '{1'b1, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;

    logic        pr  [c_N];
    logic [11:0] rx  [c_N];
    logic [11:0] ry  [c_N];
    logic        hs  [c_N];
    logic        vs  [c_N];
    logic        de  [c_N];
    logic [11:0] px  [c_N];
    logic [11:0] py  [c_N];
    logic        sf  [c_N];

    int n_cmp = 0;
    int n_err = 0;

    // Model: linear frame position of the counters, plus the history of decoded
    // positions (-1 = nothing / inactive) for the last few clocks
    int m_pos = 0;
    int m_hist [5] = '{-1, -1, -1, -1, -1};

    always #5 clk = ~clk;

    disp_timing_gen #(
        .H_ACTIVE(c_HA), .H_FP(c_HF), .H_SYNC(c_HS), .H_BP(c_HB),
        .V_ACTIVE(c_VA), .V_FP(c_VF), .V_SYNC(c_VS), .V_BP(c_VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .PREFETCH(2)
    ) u_dut0 (
        .clk(clk), .rstn(rstn), .en(en),
        .pix_req(pr[0]), .req_x(rx[0]), .req_y(ry[0]),
        .hsync(hs[0]), .vsync(vs[0]), .de(de[0]),
        .pix_x(px[0]), .pix_y(py[0]), .sof(sf[0])
    );

    disp_timing_gen #(
        .H_ACTIVE(c_HA), .H_FP(c_HF), .H_SYNC(c_HS), .H_BP(c_HB),
        .V_ACTIVE(c_VA), .V_FP(c_VF), .V_SYNC(c_VS), .V_BP(c_VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .PREFETCH(0)
    ) u_dut1 (
        .clk(clk), .rstn(rstn), .en(en),
        .pix_req(pr[1]), .req_x(rx[1]), .req_y(ry[1]),
        .hsync(hs[1]), .vsync(vs[1]), .de(de[1]),
        .pix_x(px[1]), .pix_y(py[1]), .sof(sf[1])
    );

    disp_timing_gen #(
        .H_ACTIVE(c_HA), .H_FP(c_HF), .H_SYNC(c_HS), .H_BP(c_HB),
        .V_ACTIVE(c_VA), .V_FP(c_VF), .V_SYNC(c_VS), .V_BP(c_VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .PREFETCH(4)
    ) u_dut2 (
        .clk(clk), .rstn(rstn), .en(en),
        .pix_req(pr[2]), .req_x(rx[2]), .req_y(ry[2]),
        .hsync(hs[2]), .vsync(vs[2]), .de(de[2]),
        .pix_x(px[2]), .pix_y(py[2]), .sof(sf[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // What the raster rules say about one position of the frame
    task automatic decode(input int p, output bit req, output int x, output int y,
                          output bit hact, output bit vact, output bit sofp);
        int col, row;
        req = 0; x = 0; y = 0; hact = 0; vact = 0; sofp = 0;
        if (p >= 0) begin
            col  = p % c_HT;
            row  = p / c_HT;
            req  = (col < c_HA) && (row < c_VA);
            x    = req ? col : 0;
            y    = req ? row : 0;
            hact = (col >= c_HA + c_HF) && (col < c_HA + c_HF + c_HS);
            vact = (row >= c_VA + c_VF) && (row < c_VA + c_VF + c_VS);
            sofp = (p == 0);
        end
    endtask

    task automatic check_all(input int cyc);
        bit q, ha, va, so;
        int x, y;
        for (int i = 0; i < c_N; i++) begin
            decode(m_hist[0], q, x, y, ha, va, so);
            chk($sformatf("u%0d.pix_req@%0d", i, cyc), 32'(pr[i]), 32'(q));
            chk($sformatf("u%0d.req_x@%0d",   i, cyc), 32'(rx[i]), 32'(x));
            chk($sformatf("u%0d.req_y@%0d",   i, cyc), 32'(ry[i]), 32'(y));
            decode(m_hist[c_PF[i]], q, x, y, ha, va, so);
            chk($sformatf("u%0d.de@%0d",    i, cyc), 32'(de[i]), 32'(q));
            chk($sformatf("u%0d.pix_x@%0d", i, cyc), 32'(px[i]), 32'(x));
            chk($sformatf("u%0d.pix_y@%0d", i, cyc), 32'(py[i]), 32'(y));
            chk($sformatf("u%0d.sof@%0d",   i, cyc), 32'(sf[i]), 32'(so));
            chk($sformatf("u%0d.hsync@%0d", i, cyc), 32'(hs[i]),
                32'(ha ? c_HPOL[i] : !c_HPOL[i]));
            chk($sformatf("u%0d.vsync@%0d", i, cyc), 32'(vs[i]),
                32'(va ? c_VPOL[i] : !c_VPOL[i]));
        end
    endtask

    // Apply inputs for one clock, advance the model across that edge, check just after it
    task automatic tick(input logic r, input logic e, input int cyc);
        rstn = r;
        en   = e;
        @(posedge clk);
        #1;
        if (!r) begin
            for (int k = 0; k < 5; k++) m_hist[k] = -1;
            m_pos = 0;
        end else begin
            for (int k = 4; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = e ? m_pos : -1;
            m_pos     = e ? (m_pos + 1) % c_FRAME : 0;
        end
        check_all(cyc);
    endtask

    initial begin
        int c;
        int sof_a, sof_b;

        // Reset with en high: all outputs at reset values
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, -1);

        // Two-plus frames from release; clock 1 is the first edge with rstn high
        sof_a = -1;
        sof_b = -1;
        for (c = 1; c <= 2 * c_FRAME + 10; c++) begin
            tick(1'b1, 1'b1, c);
            if (sf[0] === 1'b1) begin
                if (sof_a < 0) sof_a = c;
                else if (sof_b < 0) sof_b = c;
            end
        end
        chk("first_sof_clock", 32'(sof_a), 32'd3);
        chk("sof_spacing", 32'(sof_b - sof_a), 32'(c_FRAME));

        // Move into line 2, then drop en mid-line and restart
        while (m_pos != 2 * c_HT + 3) tick(1'b1, 1'b1, c++);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, c++);
        for (int i = 0; i < 30; i++) tick(1'b1, 1'b1, c++);

        // Reset for one clock mid-active-line with en low, then a clean restart
        while (m_pos % c_HT != 4 || m_pos / c_HT >= c_VA) tick(1'b1, 1'b1, c++);
        tick(1'b0, 1'b0, c++);
        for (int i = 0; i < c_FRAME + 10; i++) tick(1'b1, 1'b1, c++);

        // Random disturbances of rstn and en
        for (int i = 0; i < 700; i++) begin
            tick(logic'($urandom_range(0, 59) != 0), logic'($urandom_range(0, 24) != 0), c++);
        end

        // Clean tail crossing a frame wrap
        for (int i = 0; i < c_FRAME + 20; i++) tick(1'b1, 1'b1, c++);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
